// File: rtl/fvb_pkg.sv
// Shared types and the 4-bit quantizer for the feature vector builder.
// Build option: QUANT_ROUND_EN selects round-to-nearest with saturation instead of truncation.
package fvb_pkg;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        REQ     = 2'd1,
        WAITLOW = 2'd2,
        DROP    = 2'd3
    } state_e;

    localparam int QBITS    = 4;
    localparam int PIX_BITS = 8;

    function automatic logic [QBITS-1:0] quantize(input logic [PIX_BITS-1:0] avg);
`ifdef QUANT_ROUND_EN
        logic [4:0] r;
        r = 5'(({1'b0, avg} + 9'd8) >> 4);
        return (r > 5'd15) ? 4'hF : r[3:0];
`else
        return QBITS'(avg >> (PIX_BITS - QBITS));
`endif
    endfunction

endpackage

// File: rtl/fvb_pool_quant.sv
// Average-pools runs of POOL pixels and quantizes each average to one vector element.
// elem_valid is combinational so the element lands in the vector on the accepting edge.
module fvb_pool_quant
    import fvb_pkg::*;
#(
    parameter int POOL = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                acc_en,
    input  logic                clr,
    input  logic [PIX_BITS-1:0] pix,
    output logic                elem_valid,
    output logic [QBITS-1:0]    elem
);

    localparam int LOG2P = $clog2(POOL);
    localparam int ACC_W = PIX_BITS + LOG2P;
    localparam int PC_W  = (POOL > 1) ? LOG2P : 1;
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(POOL - 1);

    logic [ACC_W-1:0]    acc_q, acc_d, sum_s;
    logic [PC_W-1:0]     pix_cnt_q, pix_cnt_d;
    logic [PIX_BITS-1:0] avg_s;

    // Accumulate the pool; clr wins so an aborted frame restarts cleanly.
    always_comb begin
        sum_s      = acc_q + ACC_W'(pix);
        avg_s      = sum_s[LOG2P +: PIX_BITS];
        elem       = quantize(avg_s);
        elem_valid = acc_en && (pix_cnt_q == PC_LAST);
        acc_d      = acc_q;
        pix_cnt_d  = pix_cnt_q;
        if (clr) begin
            acc_d     = '0;
            pix_cnt_d = '0;
        end else if (acc_en) begin
            if (pix_cnt_q == PC_LAST) begin
                acc_d     = '0;
                pix_cnt_d = '0;
            end else begin
                acc_d     = sum_s;
                pix_cnt_d = pix_cnt_q + PC_W'(1);
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator and pixel counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            pix_cnt_q <= '0;
        end else begin
            acc_q     <= acc_d;
            pix_cnt_q <= pix_cnt_d;
        end
    end

endmodule

// File: rtl/feature_vector_builder.sv
// Packs pooled/quantized pixels into a vector and runs the start/done classifier handshake.
// Build option: QUANT_ROUND_EN (see fvb_pkg) changes the element quantization.
module feature_vector_builder
    import fvb_pkg::*;
#(
    parameter int VECTOR_SIZE = 1024,
    parameter int VECTOR_BITS = VECTOR_SIZE * 4,
    parameter int POOL        = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PIX_BITS-1:0]    in_data,
    input  logic                   in_last,
    output logic                   cls_start,
    output logic [VECTOR_BITS-1:0] test_vector,
    input  logic                   cls_result,
    input  logic                   cls_done,
    output logic                   res_valid,
    output logic                   res_data,
    output logic                   frame_err
);

    localparam int EC_W = $clog2(VECTOR_SIZE);
    localparam logic [EC_W-1:0] EC_LAST = EC_W'(VECTOR_SIZE - 1);

    state_e                 state_q, state_d;
    logic [EC_W-1:0]        elem_cnt_q, elem_cnt_d;
    logic [VECTOR_BITS-1:0] vec_q, vec_d;
    logic                   in_ready_q, in_ready_d;
    logic                   cls_start_q, cls_start_d;
    logic                   armed_q, armed_d;
    logic                   res_valid_q, res_valid_d;
    logic                   res_data_q, res_data_d;
    logic                   frame_err_q, frame_err_d;
    logic                   fire_s, acc_en_s, clr_s, elem_valid_s, is_final_s;
    logic [QBITS-1:0]       elem_s;

    assign fire_s     = in_valid && in_ready_q;
    assign acc_en_s   = fire_s && (state_q == FILL);
    assign is_final_s = elem_valid_s && (elem_cnt_q == EC_LAST);

    fvb_pool_quant #(.POOL(POOL)) u_pool (
        .clk        (clk),
        .rst        (rst),
        .acc_en     (acc_en_s),
        .clr        (clr_s),
        .pix        (in_data),
        .elem_valid (elem_valid_s),
        .elem       (elem_s)
    );

    // Next-state, vector packing and registered-output values.
    always_comb begin
        state_d     = state_q;
        elem_cnt_d  = elem_cnt_q;
        vec_d       = vec_q;
        in_ready_d  = in_ready_q;
        cls_start_d = cls_start_q;
        armed_d     = armed_q;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        frame_err_d = 1'b0;
        clr_s       = 1'b0;
        if (elem_valid_s) begin
            vec_d[int'(elem_cnt_q) * QBITS +: QBITS] = elem_s;
            elem_cnt_d = elem_cnt_q + EC_W'(1);
        end else begin
            vec_d = vec_q;
        end
        case (state_q)
            FILL: begin
                if (acc_en_s && in_last && !is_final_s) begin
                    frame_err_d = 1'b1;
                    clr_s       = 1'b1;
                    elem_cnt_d  = '0;
                end else if (is_final_s && !in_last) begin
                    frame_err_d = 1'b1;
                    clr_s       = 1'b1;
                    elem_cnt_d  = '0;
                    state_d     = DROP;
                end else if (is_final_s) begin
                    state_d     = REQ;
                    in_ready_d  = 1'b0;
                    cls_start_d = 1'b1;
                    armed_d     = 1'b0;
                end else begin
                    state_d = FILL;
                end
            end
            REQ: begin
                // A done level seen in the first REQ cycle predates this start.
                if (!armed_q) begin
                    armed_d = 1'b1;
                end else if (cls_done) begin
                    res_valid_d = 1'b1;
                    res_data_d  = cls_result;
                    cls_start_d = 1'b0;
                    state_d     = WAITLOW;
                end else begin
                    state_d = REQ;
                end
            end
            WAITLOW: begin
                if (!cls_done) begin
                    state_d    = FILL;
                    in_ready_d = 1'b1;
                    clr_s      = 1'b1;
                    elem_cnt_d = '0;
                end else begin
                    state_d = WAITLOW;
                end
            end
            DROP: begin
                if (fire_s && in_last) begin
                    state_d    = FILL;
                    clr_s      = 1'b1;
                    elem_cnt_d = '0;
                end else begin
                    state_d = DROP;
                end
            end
            default: begin
                state_d     = FILL;
                in_ready_d  = 1'b1;
                cls_start_d = 1'b0;
                clr_s       = 1'b1;
                elem_cnt_d  = '0;
            end
        endcase
    end

    // State, vector and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            elem_cnt_q  <= '0;
            vec_q       <= '0;
            in_ready_q  <= 1'b1;
            cls_start_q <= 1'b0;
            armed_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            elem_cnt_q  <= elem_cnt_d;
            vec_q       <= vec_d;
            in_ready_q  <= in_ready_d;
            cls_start_q <= cls_start_d;
            armed_q     <= armed_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign cls_start   = cls_start_q;
    assign test_vector = vec_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_feature_vector_builder.sv
// Self-checking bench for feature_vector_builder (VECTOR_SIZE=16, POOL=4).
// Table of uniform frames, hand-written error/handshake sequences, and random frames vs a pooling model.
module tb_feature_vector_builder;

    localparam int VS = 16;
    localparam int P  = 4;
    localparam int VB = VS * 4;
    localparam int NP = VS * P;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_data = 8'd0;
    logic          in_last = 1'b0;
    logic          cls_start;
    logic [VB-1:0] test_vector;
    logic          cls_result = 1'b0;
    logic          cls_done = 1'b0;
    logic          res_valid;
    logic          res_data;
    logic          frame_err;

    int n_checks = 0;
    int n_fail   = 0;
    int fe_cnt   = 0;
    int frame_pix [0:NP-1];

    typedef struct {
        logic [7:0] pix;
        logic [3:0] exp_elem;
        logic       result;
    } vec_t;
    vec_t tbl [6];

    feature_vector_builder #(.VECTOR_SIZE(VS), .VECTOR_BITS(VB), .POOL(P)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .cls_start   (cls_start),
        .test_vector (test_vector),
        .cls_result  (cls_result),
        .cls_done    (cls_done),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference: mean of each run of P pixels, then 4-bit quantization.
    function automatic logic [63:0] model_vec();
        logic [63:0] v;
        int s, avg, q;
        v = '0;
        for (int k = 0; k < VS; k++) begin
            s = 0;
            for (int j = 0; j < P; j++) s += frame_pix[k*P + j];
            avg = s / P;
`ifdef QUANT_ROUND_EN
            q = (avg + 8) / 16;
            if (q > 15) q = 15;
`else
            q = avg / 16;
`endif
            v[k*4 +: 4] = q[3:0];
        end
        return v;
    endfunction

    task automatic send_frame(input int n, input int last_idx, input int gap_max);
        logic ok;
        int   guard;
        for (int i = 0; i < n; i++) begin
            if (gap_max > 0) begin
                repeat ($urandom_range(gap_max, 0)) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                end
            end
            if (i == n - 1) chk("start_early", cls_start, 1'b0);
            guard = 0;
            ok = 1'b0;
            while (!ok && guard < 200) begin
                @(negedge clk);
                in_valid = 1'b1;
                in_data  = 8'(frame_pix[i]);
                in_last  = (i == last_idx);
                ok = in_ready;
                @(posedge clk);
                guard++;
            end
            if (!ok) chk("accept_timeout", 1'b0, 1'b1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic classify(input int dly, input logic res);
        int n;
        n = 0;
        while (cls_start !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("start_seen", cls_start, 1'b1);
        repeat (dly) @(negedge clk);
        chk("ready_low_req", in_ready, 1'b0);
        cls_result = res;
        cls_done   = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (res_valid !== 1'b1 && n < 20);
        chk("res_valid", res_valid, 1'b1);
        chk("res_data", res_data, res);
        @(negedge clk);
        chk("res_pulse", res_valid, 1'b0);
        chk("start_drop", cls_start, 1'b0);
        repeat (2) @(negedge clk);
        chk("ready_low_waitlow", in_ready, 1'b0);
        cls_done = 1'b0;
        @(negedge clk);
        chk("ready_back", in_ready, 1'b1);
    endtask

    initial begin
        logic [63:0] exp_v;
        int fe0;

        tbl[0] = '{pix: 8'hA7, exp_elem: 4'hA, result: 1'b1};
        tbl[1] = '{pix: 8'h00, exp_elem: 4'h0, result: 1'b0};
        tbl[2] = '{pix: 8'hFF, exp_elem: 4'hF, result: 1'b1};
        tbl[3] = '{pix: 8'hF9, exp_elem: 4'hF, result: 1'b0};
`ifdef QUANT_ROUND_EN
        tbl[4] = '{pix: 8'h18, exp_elem: 4'h2, result: 1'b1};
        tbl[5] = '{pix: 8'h0F, exp_elem: 4'h1, result: 1'b0};
`else
        tbl[4] = '{pix: 8'h18, exp_elem: 4'h1, result: 1'b1};
        tbl[5] = '{pix: 8'h0F, exp_elem: 4'h0, result: 1'b0};
`endif

        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_cls_start", cls_start, 1'b0);
        chk("rst_vector", test_vector, 64'd0);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        rst = 1'b0;

        // Uniform frames from the table.
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < NP; i++) frame_pix[i] = int'(tbl[t].pix);
            send_frame(NP, NP - 1, 0);
            chk("start_latency", cls_start, 1'b1);
            exp_v = {VS{tbl[t].exp_elem}};
            chk("uniform_vector", test_vector, exp_v);
            chk("uniform_model", test_vector, model_vec());
            classify(5, tbl[t].result);
        end

        // Ramp: element k has value 16k.
        for (int i = 0; i < NP; i++) frame_pix[i] = 16 * (i / P);
        send_frame(NP, NP - 1, 0);
        chk("ramp_vector", test_vector, 64'hFEDC_BA98_7654_3210);
        classify(5, 1'b1);

        // Early in_last on pixel 40.
        for (int i = 0; i < NP; i++) frame_pix[i] = int'($urandom_range(255, 0));
        send_frame(41, 40, 0);
        chk("early_last_err", frame_err, 1'b1);
        @(negedge clk);
        chk("early_last_pulse", frame_err, 1'b0);
        chk("early_last_nostart", cls_start, 1'b0);
        for (int i = 0; i < NP; i++) frame_pix[i] = int'($urandom_range(255, 0));
        send_frame(NP, NP - 1, 0);
        chk("after_err_vector", test_vector, model_vec());
        classify(3, 1'b0);

        // Final pixel without in_last, then a 10-pixel tail absorbed by DROP.
        fe0 = fe_cnt;
        send_frame(NP, -1, 0);
        chk("missing_last_err", frame_err, 1'b1);
        send_frame(10, 9, 1);
        @(negedge clk);
        chk("drop_err_count", 64'(fe_cnt - fe0), 64'd1);
        chk("drop_nostart", cls_start, 1'b0);
        chk("drop_ready", in_ready, 1'b1);
        for (int i = 0; i < NP; i++) frame_pix[i] = int'($urandom_range(255, 0));
        send_frame(NP, NP - 1, 0);
        chk("after_drop_vector", test_vector, model_vec());
        classify(2, 1'b1);

        // cls_done already high when REQ is entered.
        cls_done   = 1'b1;
        cls_result = 1'b0;
        for (int i = 0; i < NP; i++) frame_pix[i] = int'($urandom_range(255, 0));
        send_frame(NP, NP - 1, 0);
        chk("prehigh_start", cls_start, 1'b1);
        chk("prehigh_no_early_res", res_valid, 1'b0);
        begin
            int n;
            n = 0;
            while (res_valid !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        chk("prehigh_res_valid", res_valid, 1'b1);
        chk("prehigh_res_data", res_data, 1'b0);
        cls_done = 1'b0;
        @(negedge clk);
        chk("prehigh_ready_back", in_ready, 1'b1);

        // Random frames with backpressure gaps.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NP; i++) frame_pix[i] = int'($urandom_range(255, 0));
            send_frame(NP, NP - 1, 3);
            chk("rand_vector", test_vector, model_vec());
            classify(int'($urandom_range(6, 1)), 1'($urandom_range(1, 0)));
        end

        // Reset in the middle of REQ.
        for (int i = 0; i < NP; i++) frame_pix[i] = int'($urandom_range(255, 0));
        send_frame(NP, NP - 1, 2);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midreq_rst_start", cls_start, 1'b0);
        chk("midreq_rst_ready", in_ready, 1'b1);
        chk("midreq_rst_vector", test_vector, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NP; i++) frame_pix[i] = int'($urandom_range(255, 0));
        send_frame(NP, NP - 1, 3);
        chk("post_rst_vector", test_vector, model_vec());
        classify(4, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
